imem_dmem_arbiter: RTL and testbench

- Shares the single port of the unified instruction/data memory between two requesters:
  - the instruction-fetch stage (fetch port)
  - the load/store stage (data port)
- Arbitrates each cycle and drives the memory port.
- Tracks the one outstanding read (memory read latency is 1 cycle) and returns its data to the requester that owns it.
- Data has priority; a starvation counter guarantees fetch forward progress.

---
 rtl/imem_dmem_arbiter.sv | 114 +++++++++++
 tb/tb_imem_dmem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
// Shares the single port of the unified instruction/data memory between the
// instruction-fetch stage and the load/store stage. Data requests have
// priority. A starvation counter forces a fetch grant after STARVE_LIMIT
// consecutive data grants while fetch was waiting. The one outstanding read
// (1-cycle memory latency) is tracked and returned to the requester that
// issued it.
//
// Handshake: a requester raises *_req with address/data and holds them stable
// until it sees *_gnt high in the same cycle (combinational grant). A granted
// read returns exactly one cycle later as *_rvalid with *_rdata. Writes never
// return rvalid. Non-owner rdata is held at zero.
module imem_dmem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic [1:0]        dbg_rd_owner,
   output logic [3:0]        dbg_starve_cnt
);

   localparam logic [1:0] OWN_IDLE  = 2'd0;
   localparam logic [1:0] OWN_FETCH = 2'd1;
   localparam logic [1:0] OWN_DATA  = 2'd2;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [1:0] rd_owner;
   logic [3:0] starve_cnt;

   // Arbitration: data wins unless fetch has waited LIMIT data grants; no grants in reset.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (reset) begin
         if (d_req && !(if_req && (starve_cnt == LIMIT))) begin
            d_gnt = 1'b1;
         end else if (if_req) begin
            if_gnt = 1'b1;
         end
      end
   end

   // Memory port mux: winner drives address and write data; fetch writes nothing.
   always_comb begin
      mem_en    = if_gnt | d_gnt;
      mem_we    = d_gnt & d_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (d_gnt) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (if_gnt) begin
         mem_addr  = if_addr;
      end
   end

   // Read return routing: only the owner of the returning read sees data.
   always_comb begin
      if_rvalid = (rd_owner == OWN_FETCH);
      d_rvalid  = (rd_owner == OWN_DATA);
      if_rdata  = if_rvalid ? mem_rdata : '0;
      d_rdata   = d_rvalid  ? mem_rdata : '0;
      stall_if  = reset & if_req & ~if_gnt;
   end

   // Remember who owns the read issued this cycle; writes leave no owner.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_owner <= OWN_IDLE;
      end else if (if_gnt) begin
         rd_owner <= OWN_FETCH;
      end else if (d_gnt && !d_we) begin
         rd_owner <= OWN_DATA;
      end else begin
         rd_owner <= OWN_IDLE;
      end
   end

   // Count consecutive data grants while fetch waits, saturating at LIMIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= 4'd0;
      end else if (if_gnt || !if_req) begin
         starve_cnt <= 4'd0;
      end else if (d_gnt && (starve_cnt != LIMIT)) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   assign dbg_rd_owner   = rd_owner;
   assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Testbench for imem_dmem_arbiter: directed scenarios plus constrained-random
// traffic, checked by a scoreboard against a transaction-level model.
module tb_imem_dmem_arbiter;

   localparam int LIM = 4;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] cyc = 32'd0;
   always @(posedge clk) cyc <= cyc + 32'd1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- DUT ----------------
   logic        if_req = 1'b0, if_gnt, if_rvalid;
   logic [31:0] if_addr = '0, if_rdata;
   logic        d_req = 1'b0, d_we = 1'b0, d_gnt, d_rvalid;
   logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
   logic        mem_en, mem_we, stall_if;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic [1:0]  dbg_rd_owner;
   logic [3:0]  dbg_starve_cnt;

   imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_if(stall_if),
      .dbg_rd_owner(dbg_rd_owner), .dbg_starve_cnt(dbg_starve_cnt)
   );

   // ---------------- memories ----------------
   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h13579BDF;
   endfunction

   // phys_mem sits on the DUT memory port; ref_mem belongs to the model.
   logic [31:0] phys_mem [0:255];
   logic [31:0] ref_mem  [0:255];
   initial begin
      for (int i = 0; i < 256; i++) begin
         phys_mem[i] = init_word(32'(i) << 2);
         ref_mem[i]  = init_word(32'(i) << 2);
      end
   end

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) phys_mem[mem_addr[9:2]] <= mem_wdata;
         else        mem_rdata <= phys_mem[mem_addr[9:2]];
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic        ig;
      logic        dg;
      logic        we;
      logic        stall;
      logic [31:0] addr;
      logic [31:0] wdata;
   } gexp_t;

   gexp_t       g_q[$];
   logic [63:0] if_exp_q[$];   // {expected cycle, data}
   logic [63:0] d_exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic        mon_en = 1'b0;
   int          waits = 0;     // data grants given while fetch kept waiting

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive_cycle(input logic fr, input logic [31:0] fa,
                              input logic dr, input logic dwe,
                              input logic [31:0] da, input logic [31:0] dwd,
                              output logic fg, output logic dg);
      gexp_t e;
      @(posedge clk);
      #1;
      if_req = fr; if_addr = fa;
      d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
      fg = fr && (!dr || waits == LIM);
      dg = dr && !fg;
      e.ig    = fg;
      e.dg    = dg;
      e.we    = dg && dwe;
      e.stall = fr && !fg;
      e.addr  = fg ? fa : da;
      e.wdata = dg ? dwd : 32'd0;
      g_q.push_back(e);
      if (fg) if_exp_q.push_back({cyc + 32'd1, ref_mem[fa[9:2]]});
      if (dg && !dwe) d_exp_q.push_back({cyc + 32'd1, ref_mem[da[9:2]]});
      if (dg && dwe) ref_mem[da[9:2]] = dwd;
      if (fg || !fr) waits = 0;
      else if (dg && waits < LIM) waits = waits + 1;
   endtask

   task automatic idle_cycles(input int n);
      logic a, b;
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, a, b);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      gexp_t       e;
      logic [63:0] x;
      if (mon_en) begin
         if (g_q.size() > 0) begin
            e = g_q.pop_front();
            chk("if_gnt", 64'(if_gnt), 64'(e.ig));
            chk("d_gnt", 64'(d_gnt), 64'(e.dg));
            chk("mem_en", 64'(mem_en), 64'(e.ig | e.dg));
            chk("mem_we", 64'(mem_we), 64'(e.we));
            chk("stall_if", 64'(stall_if), 64'(e.stall));
            if (e.ig || e.dg) chk("mem_addr", 64'(mem_addr), 64'(e.addr));
            if (e.ig || e.we) chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
         end
         if (if_rvalid) begin
            if (if_exp_q.size() == 0) chk("if_rvalid_unexpected", 64'd1, 64'd0);
            else begin
               x = if_exp_q.pop_front();
               chk("if_rvalid_cycle", 64'(cyc), 64'(x[63:32]));
               chk("if_rdata", 64'(if_rdata), 64'(x[31:0]));
            end
         end else chk("if_rdata_idle", 64'(if_rdata), 64'd0);
         if (d_rvalid) begin
            if (d_exp_q.size() == 0) chk("d_rvalid_unexpected", 64'd1, 64'd0);
            else begin
               x = d_exp_q.pop_front();
               chk("d_rvalid_cycle", 64'(cyc), 64'(x[63:32]));
               chk("d_rdata", 64'(d_rdata), 64'(x[31:0]));
            end
         end else chk("d_rdata_idle", 64'(d_rdata), 64'd0);
         while (if_exp_q.size() > 0) begin
            x = if_exp_q[0];
            if (x[63:32] >= cyc) break;
            void'(if_exp_q.pop_front());
            chk("if_rvalid_missing", 64'd0, 64'd1);
         end
         while (d_exp_q.size() > 0) begin
            x = d_exp_q[0];
            if (x[63:32] >= cyc) break;
            void'(d_exp_q.pop_front());
            chk("d_rvalid_missing", 64'd0, 64'd1);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic contention6();
      logic a, b;
      for (int i = 0; i < 6; i++) drive_cycle(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'd0, a, b);
   endtask

   task automatic random_traffic(input int n);
      logic        f_pend = 1'b0, d_pend = 1'b0, dwe = 1'b0, fg, dg;
      logic [31:0] fa = '0, da = '0, dwd = '0;
      for (int i = 0; i < n; i++) begin
         if (!f_pend && $urandom_range(0, 3) != 0) begin
            f_pend = 1'b1;
            fa = 32'($urandom_range(0, 31)) << 2;
         end
         if (!d_pend && $urandom_range(0, 2) != 0) begin
            d_pend = 1'b1;
            dwe = ($urandom_range(0, 2) == 0);
            da  = 32'($urandom_range(0, 31)) << 2;
            dwd = $urandom;
         end
         drive_cycle(f_pend, fa, d_pend, dwe, da, dwd, fg, dg);
         if (fg) f_pend = 1'b0;
         if (dg) d_pend = 1'b0;
      end
   endtask

   initial begin
      logic a, b;
      // Reset held with both requests asserted: everything must stay quiet.
      if_req = 1'b1; d_req = 1'b1; d_addr = 32'h100;
      repeat (2) @(negedge clk);
      chk("rst_if_gnt", 64'(if_gnt), 64'd0);
      chk("rst_d_gnt", 64'(d_gnt), 64'd0);
      chk("rst_mem_en", 64'(mem_en), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_stall_if", 64'(stall_if), 64'd0);
      chk("rst_if_rvalid", 64'(if_rvalid), 64'd0);
      chk("rst_d_rvalid", 64'(d_rvalid), 64'd0);
      chk("rst_if_rdata", 64'(if_rdata), 64'd0);
      chk("rst_d_rdata", 64'(d_rdata), 64'd0);
      chk("rst_starve_cnt", 64'(dbg_starve_cnt), 64'd0);
      if_req = 1'b0; d_req = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      mon_en = 1'b1;

      // Fetch only, four sequential words.
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'd0, 32'd0, a, b);
      idle_cycles(2);
      // Contention: 4 data grants, one fetch, one data.
      contention6();
      idle_cycles(2);
      // Store then load of the same word.
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, a, b);
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'h200, 32'd0, a, b);
      idle_cycles(2);
      // Interleaved ownership.
      drive_cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, a, b);
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0, a, b);
      idle_cycles(2);
      // Idle stretch.
      idle_cycles(10);
      random_traffic(400);
      idle_cycles(3);
      chk("drain_if_q", 64'(if_exp_q.size()), 64'd0);
      chk("drain_d_q", 64'(d_exp_q.size()), 64'd0);

      // Reset in the middle of a fetch stream.
      mon_en = 1'b0;
      @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h80;
      #1 chk("mid_gnt_before", 64'(if_gnt), 64'd1);
      @(posedge clk); #1 if_addr = 32'h84;
      #1 chk("mid_rvalid_before", 64'(if_rvalid), 64'd1);
      chk("mid_rdata_before", 64'(if_rdata), 64'(ref_mem[32]));
      reset = 1'b0;
      #1 chk("mid_if_gnt", 64'(if_gnt), 64'd0);
      chk("mid_mem_en", 64'(mem_en), 64'd0);
      chk("mid_stall_if", 64'(stall_if), 64'd0);
      chk("mid_if_rvalid", 64'(if_rvalid), 64'd0);
      chk("mid_if_rdata", 64'(if_rdata), 64'd0);
      if_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      g_q.delete(); if_exp_q.delete(); d_exp_q.delete();
      waits = 0;
      mon_en = 1'b1;
      idle_cycles(4);
      chk("post_rst_starve_cnt", 64'(dbg_starve_cnt), 64'd0);
      contention6();
      idle_cycles(2);
      random_traffic(100);
      idle_cycles(3);
      chk("final_if_q", 64'(if_exp_q.size()), 64'd0);
      chk("final_d_q", 64'(d_exp_q.size()), 64'd0);
      mon_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
